mux2_1_sync: RTL and testbench

- Width-parameterized 2:1 selector; leaf cell of the single-cycle CPU datapath mux trees.
- Three instances compose a 4:1 mux: two on sel[0], one on sel[1].
- Provides a purely combinational output (the primary datapath path) and a registered copy with enable, for pipelining/observation.
- With WIDTH=1 it is a drop-in 1-bit cell with port names out, in, sel.

---
 rtl/mux2_1_sync.sv | 33 +++
 tb/tb_mux2_1_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux2_1_sync.sv
// Width-parameterized 2:1 selector with a combinational output and an
// enabled, asynchronously reset registered copy of the selected value.
module mux2_1_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] in,
  input  logic               sel,
  input  logic               en,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q
);

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;

  assign in0 = in[WIDTH-1:0];
  assign in1 = in[2*WIDTH-1:WIDTH];

  // Conditional operator rather than if/else: an unknown sel then yields X only
  // on the bits where the two inputs disagree.
  assign out = sel ? in1 : in0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux2_1_sync.sv
// Directed bench for mux2_1_sync: 1-bit cell, 8-bit cell and a 4:1 tree of
// three 1-bit cells.
module tb_mux2_1_sync;

  logic       clk;
  logic       reset;
  logic       en;

  logic [1:0] in1b;
  logic       sel1b;
  logic       out1b;
  logic       q1b;

  logic [15:0] in8;
  logic        sel8;
  logic [7:0]  out8;
  logic [7:0]  q8;

  logic [3:0] in4;
  logic [1:0] sel2;
  logic       lo_out, hi_out, top_out;
  logic       lo_q, hi_q, top_q;

  int n_cmp = 0;
  int n_err = 0;

  mux2_1_sync #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in(in1b), .sel(sel1b), .en(en),
    .out(out1b), .out_q(q1b)
  );

  mux2_1_sync #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in(in8), .sel(sel8), .en(en),
    .out(out8), .out_q(q8)
  );

  mux2_1_sync #(.WIDTH(1)) u_lo (
    .clk(clk), .reset(reset), .in(in4[1:0]), .sel(sel2[0]), .en(en),
    .out(lo_out), .out_q(lo_q)
  );

  mux2_1_sync #(.WIDTH(1)) u_hi (
    .clk(clk), .reset(reset), .in(in4[3:2]), .sel(sel2[0]), .en(en),
    .out(hi_out), .out_q(hi_q)
  );

  mux2_1_sync #(.WIDTH(1)) u_top (
    .clk(clk), .reset(reset), .in({hi_out, lo_out}), .sel(sel2[1]), .en(en),
    .out(top_out), .out_q(top_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    in1b  = 2'b00;
    sel1b = 1'b0;
    in8   = 16'h0000;
    sel8  = 1'b0;
    in4   = 4'b0000;
    sel2  = 2'b00;
    #1;
    check_eq("reset_q1", {7'b0, q1b}, 8'h00);
    check_eq("reset_q8", q8, 8'h00);

    // Exhaustive 1-bit truth table while held in reset, clock running
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v     = i[2:0];
      in1b  = v[1:0];
      sel1b = v[2];
      #10;
      check_eq($sformatf("tt_out_%0d", i), {7'b0, out1b}, {7'b0, v[2] ? v[1] : v[0]});
      check_eq($sformatf("tt_q_%0d", i), {7'b0, q1b}, 8'h00);
    end

    // Walking bit: selected bit is tracked, unselected bit is ignored
    for (int s = 0; s < 2; s++) begin
      sel1b = s[0];
      in1b  = 2'b00;
      #10;
      in1b[s] = 1'b1; #10;
      check_eq($sformatf("walk_sel%0d_hi", s), {7'b0, out1b}, 8'h01);
      in1b[s] = 1'b0; #10;
      check_eq($sformatf("walk_sel%0d_lo", s), {7'b0, out1b}, 8'h00);
      in1b[1-s] = 1'b1; #10;
      check_eq($sformatf("walk_sel%0d_other", s), {7'b0, out1b}, 8'h00);
      in1b[1-s] = 1'b0; #10;
    end

    // Registered path
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    in1b  = 2'b10;
    sel1b = 1'b1;
    #1;
    check_eq("q_before_first_edge", {7'b0, q1b}, 8'h00);
    @(posedge clk); #1;
    check_eq("q_load_1", {7'b0, q1b}, 8'h01);
    @(negedge clk);
    sel1b = 1'b0;
    @(posedge clk); #1;
    check_eq("q_load_0", {7'b0, q1b}, 8'h00);
    @(negedge clk);
    en    = 1'b0;
    sel1b = 1'b1;
    @(posedge clk); #1;
    check_eq("q_hold_0", {7'b0, q1b}, 8'h00);
    check_eq("out_while_hold", {7'b0, out1b}, 8'h01);

    // Async reset between edges
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check_eq("q_reload_1", {7'b0, q1b}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_q", {7'b0, q1b}, 8'h00);
    check_eq("async_rst_out", {7'b0, out1b}, 8'h01);
    @(posedge clk); #1;
    check_eq("edge_in_rst_q", {7'b0, q1b}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_release_q", {7'b0, q1b}, 8'h00);
    @(posedge clk); #1;
    check_eq("first_load_after_rst", {7'b0, q1b}, 8'h01);
    @(negedge clk);
    en    = 1'b0;
    sel1b = 1'b0;
    @(posedge clk); #1;
    check_eq("q_hold_1", {7'b0, q1b}, 8'h01);
    check_eq("out_sel0", {7'b0, out1b}, 8'h00);

    // WIDTH=8
    @(negedge clk);
    en   = 1'b1;
    in8  = {8'hA5, 8'h3C};
    sel8 = 1'b0;
    #1;
    check_eq("w8_out_sel0", out8, 8'h3C);
    @(posedge clk); #1;
    check_eq("w8_q_sel0", q8, 8'h3C);
    @(negedge clk);
    sel8 = 1'b1;
    #1;
    check_eq("w8_out_sel1", out8, 8'hA5);
    check_eq("w8_q_lag", q8, 8'h3C);
    @(posedge clk); #1;
    check_eq("w8_q_sel1", q8, 8'hA5);

    // 4:1 composition
    for (int s = 0; s < 4; s++) begin
      sel2 = s[1:0];
      in4  = 4'b1111;
      in4[s] = 1'b0;
      #10;
      check_eq($sformatf("mux4_sel%0d_0", s), {7'b0, top_out}, 8'h00);
      in4 = 4'b0000;
      in4[s] = 1'b1;
      #10;
      check_eq($sformatf("mux4_sel%0d_1", s), {7'b0, top_out}, 8'h01);
    end
    @(negedge clk);
    sel2 = 2'b10;
    in4  = 4'b0100;
    @(posedge clk); #1;
    check_eq("mux4_q", {7'b0, top_q}, 8'h01);
    check_eq("mux4_lo_q", {7'b0, lo_q}, 8'h00);
    check_eq("mux4_hi_q", {7'b0, hi_q}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
